if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller for the IF stage. It holds the program counter, issues one instruction-memory request at a time, and advances the PC by one word (wrapping modulo 2^32). It also handles branch redirects from EX and delivers fetched instructions into the IF/ID pipeline register under an ID-stage stall. It feeds the ID stage directly; the PC+1 value it forwards (`ifid_npc`) is the same next-PC the IF incrementer computes.

## Interface
- `WIDTH`, 32, PC, address and instruction width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_addr`  out  WIDTH  word address of the request (current PC).
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_resp_valid`  in  1  response data valid. Pulses once per accepted request, in order, at least 1 cycle after acceptance. The block always accepts it.
- `imem_resp_data`  in  WIDTH  instruction word.
- `redirect_valid`  in  1  branch/jump taken; a 1-cycle pulse.
- `redirect_pc`  in  WIDTH  redirect target.
- `id_stall`  in  1  ID cannot consume `ifid_*` this cycle.
- `ifid_valid`  out  1  IF/ID register holds a valid instruction.
- `ifid_instr`  out  WIDTH  fetched instruction.
- `ifid_pc`  out  WIDTH  address it was fetched from.
- `ifid_npc`  out  WIDTH  `ifid_pc` + 1, mod 2^WIDTH.

## Operation
- **State**
  - `pc`: PC register.
  - FSM: FETCH, WAIT, DISCARD.
  - One-entry skid buffer: `skid_valid`, `skid_instr`, `skid_pc`.
  - `req_pc`: PC of the outstanding request.
- **Request rule:** `imem_req_valid` = (state==FETCH) & !`skid_valid` & !`redirect_valid`. `imem_req_addr` = `pc`.
- **FETCH**
  - On handshake (valid & ready): `req_pc` <= `pc`, `pc` <= `pc`+1, go to WAIT.
  - Otherwise stay in FETCH.
- **WAIT**
  - On `imem_resp_valid` without redirect: deliver {`imem_resp_data`, `req_pc`}, go to FETCH.
  - On `redirect_valid` with `imem_resp_valid` in the same cycle: drop the response, go to FETCH.
  - On `redirect_valid` without a response: go to DISCARD.
- **DISCARD:** on `imem_resp_valid`, drop the response and go to FETCH. No delivery happens in this state.
- **Deliver**
  - If `ifid_valid`=0 or `id_stall`=0 and `skid_valid`=0: load `ifid_*`.
  - Else: load the skid buffer. The skid is guaranteed empty by the request rule.
- **IF/ID advance:** when `id_stall`=0 and `ifid_valid`=1, the entry is consumed. `ifid_*` loads, in priority order:
  - the skid entry (and clears the skid), else
  - the delivered response, else
  - nothing, and `ifid_valid` <= 0.
- **Redirect** (any state) takes priority over everything:
  - `pc` <= `redirect_pc`.
  - `ifid_valid` <= 0 and `skid_valid` <= 0.
  - Any response in the same cycle is dropped.
  - Next request is to `redirect_pc`.
  - A redirect in DISCARD only updates `pc`; the FSM stays in DISCARD.
- **Width rule:** `pc`+1 and `ifid_npc` wrap: 32'hFFFF_FFFF + 1 = 32'h0000_0000, with no overflow flag.
- **Stall hold:** `id_stall`=1 with `ifid_valid`=1 holds all `ifid_*` outputs stable.

## Timing
- **Reset values:**
  - `pc`=RESET_PC, FSM=FETCH.
  - `ifid_valid`=0, `skid_valid`=0.
  - `ifid_instr`/`ifid_pc`/`ifid_npc`=0, `req_pc`=0.
  - `imem_req_valid`=1 in the first cycle after reset deasserts.
- **Reset mid-operation:** discards all state including any outstanding request. The memory shares `rst`, so no stale response arrives afterwards.
- **Latency:** with memory response latency L≥1 and no stall, `ifid_valid` rises L+1 cycles after the request handshake.
- **Throughput:** one instruction per L+1 cycles, with one request outstanding at most.
- **Stall:** at most one instruction is buffered beyond IF/ID. Requests stop while the skid is full and resume the cycle after it drains.
- **Redirect:** the first request to the target is issued the cycle after the redirect pulse, or after the discarded response if one is outstanding.

## Test plan
- **Reset, then sequential fetch:** reset, RESET_PC=0, ready=1, L=1.
  - Requests to 0, 1, 2.
  - `ifid_pc`/`ifid_npc` = 0/1, 1/2, 2/3.
  - Instructions match the memory image.
- **Wrap:** redirect to 32'hFFFF_FFFF.
  - Fetch delivers `ifid_pc`=FFFF_FFFF, `ifid_npc`=0000_0000.
  - Next request address = 0.
- **Stall with skid:** hold `id_stall`=1 across two deliveries (pc 4, 5).
  - `ifid_pc` stays 4 and no request issues while the skid is full.
  - Releasing the stall yields 5 next cycle, then requests resume at 6.
- **Redirect during WAIT (L=3):** redirect to 32'h40 one cycle after the handshake for pc 8.
  - The pc-8 response is dropped and never reaches `ifid_valid`.
  - The next request address is 32'h40.
- **Redirect coincident with response:**
  - The response is dropped and `ifid_valid`=0 the next cycle.
  - `imem_req_valid`=0 during the redirect cycle; the request to the target issues the following cycle.
- **Backpressure and mid-run reset:**
  - With `imem_req_ready`=0 for 3 cycles, `imem_req_addr` stays stable.
  - Asserting `rst` while in WAIT returns all outputs to reset values and restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch controller for the IF stage. Holds the program counter,
// keeps at most one instruction-memory request in flight, advances the PC by
// one word per accepted request (wrapping modulo 2^WIDTH), handles branch
// redirects from EX, and delivers fetched instructions into the IF/ID
// register. A one-entry skid buffer absorbs a response that arrives while ID
// is stalled on a valid IF/ID entry.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   imem_req_valid    : out, request to instruction memory
//   imem_req_addr     : out, word address of the request (current PC)
//   imem_req_ready    : in,  memory accepts the request this cycle
//   imem_resp_valid   : in,  response strobe (one per accepted request)
//   imem_resp_data    : in,  instruction word
//   redirect_valid    : in,  taken branch/jump pulse from EX
//   redirect_pc       : in,  redirect target
//   id_stall          : in,  ID cannot consume the IF/ID entry this cycle
//   ifid_valid        : out, IF/ID holds a valid instruction
//   ifid_instr        : out, fetched instruction
//   ifid_pc           : out, address it was fetched from
//   ifid_npc          : out, ifid_pc + 1 (wrapping)
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             id_stall,
    output logic             ifid_valid,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc,
    output logic [WIDTH-1:0] ifid_npc
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [WIDTH-1:0] ifid_npc_q, ifid_npc_d;

    logic req_fire;
    logic deliver;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                // A redirect already blocks the request, so no handshake
                // can happen in a redirect cycle.
                if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response always closes the outstanding request, whether
                // it is delivered or dropped by a coincident redirect.
                if (imem_resp_valid) begin
                    state_d = ST_FETCH;
                end else if (redirect_valid) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // A redirect here only moves the PC; the stale response is
                // still owed, and its arrival is what frees the FSM.
                if (imem_resp_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Requests pause while the skid is occupied so that a response can
        // never arrive with nowhere to go.
        imem_req_valid = (state_q == ST_FETCH) && !skid_valid_q && !redirect_valid;
        deliver        = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
    end

    assign imem_req_addr = pc_q;
    assign req_fire      = imem_req_valid && imem_req_ready;

    // ------------------------------------------------------------------
    // PC, outstanding-request PC, skid buffer and IF/ID register
    // ------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_npc_d   = ifid_npc_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + WIDTH'(1);
        end

        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!ifid_valid_q || !id_stall) begin
            // IF/ID is empty or being consumed: refill from the skid first
            // (older), then from the response, otherwise go empty.
            if (skid_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr_q;
                ifid_pc_d    = skid_pc_q;
                ifid_npc_d   = skid_pc_q + WIDTH'(1);
                skid_valid_d = 1'b0;
            end else if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_resp_data;
                ifid_pc_d    = req_pc_q;
                ifid_npc_d   = req_pc_q + WIDTH'(1);
            end else begin
                ifid_valid_d = 1'b0;
            end
        end else if (deliver) begin
            // ID is stalled on a valid entry; the skid is known empty
            // because no request issues while it is full.
            skid_valid_d = 1'b1;
            skid_instr_d = imem_resp_data;
            skid_pc_d    = req_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_npc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_npc_q   <= ifid_npc_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_npc   = ifid_npc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Directed bench for if_fetch_ctrl. A small instruction-memory model answers
// each accepted request after a configurable latency with an image word
// derived from the address. Each scenario task drives stimulus cycle by cycle
// and compares outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req_valid;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_req_ready;
    logic             imem_resp_valid;
    logic [WIDTH-1:0] imem_resp_data;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             id_stall;
    logic             ifid_valid;
    logic [WIDTH-1:0] ifid_instr;
    logic [WIDTH-1:0] ifid_pc;
    logic [WIDTH-1:0] ifid_npc;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model state
    int               lat      = 1;
    int               mem_rem  = 0;
    logic [WIDTH-1:0] mem_addr = '0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_npc        (ifid_npc)
    );

    function automatic logic [WIDTH-1:0] img(input logic [WIDTH-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Advance one clock. Captures the handshake before the edge, then
    // updates the memory model and drives the response for the new cycle.
    task automatic tick();
        logic             hs;
        logic [WIDTH-1:0] hs_addr;
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            mem_rem = 0;
        end else begin
            if (mem_rem > 0) mem_rem--;
            if (hs) begin
                mem_rem  = lat;
                mem_addr = hs_addr;
            end
        end
        imem_resp_valid = (mem_rem == 1);
        imem_resp_data  = imem_resp_valid ? img(mem_addr) : '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid); end
        n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ifid_valid: got %b expected 0", ifid_valid); end
        n_checks++; if ({ifid_instr, ifid_pc, ifid_npc} !== 96'h0) begin n_fail++; $display("FAIL reset_ifid_regs: got %h/%h/%h expected 0/0/0", ifid_instr, ifid_pc, ifid_npc); end
        $display("reset: req_valid=%b addr=%h ifid_valid=%b", imem_req_valid, imem_req_addr, ifid_valid);
    endtask

    task automatic test_seq_fetch();
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(k)) begin n_fail++; $display("FAIL seq_req[%0d]: got valid=%b addr=%h expected valid=1 addr=%h", k, imem_req_valid, imem_req_addr, 32'(k)); end
            tick();
            n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL seq_req_idle[%0d]: got %b expected 0", k, imem_req_valid); end
            tick();
            n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(k) || ifid_npc !== 32'(k + 1) || ifid_instr !== img(32'(k))) begin
                n_fail++; $display("FAIL seq_ifid[%0d]: got v=%b pc=%h npc=%h instr=%h expected v=1 pc=%h npc=%h instr=%h", k, ifid_valid, ifid_pc, ifid_npc, ifid_instr, 32'(k), 32'(k + 1), img(32'(k)));
            end
            $display("seq: delivered pc=%h npc=%h instr=%h", ifid_pc, ifid_npc, ifid_instr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_req_blocked: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (ifid_valid !== 1'b0 || imem_req_addr !== 32'hFFFF_FFFF || imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_target_req: got ifid_v=%b req_v=%b addr=%h expected 0/1/ffffffff", ifid_valid, imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'hFFFF_FFFF || ifid_npc !== 32'h0 || ifid_instr !== img(32'hFFFF_FFFF)) begin
            n_fail++; $display("FAIL wrap_ifid: got v=%b pc=%h npc=%h instr=%h expected v=1 pc=ffffffff npc=00000000 instr=%h", ifid_valid, ifid_pc, ifid_npc, ifid_instr, img(32'hFFFF_FFFF));
        end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got v=%b addr=%h expected v=1 addr=00000000", imem_req_valid, imem_req_addr); end
        $display("wrap: delivered pc=%h npc=%h next_req=%h", ifid_pc, ifid_npc, imem_req_addr);
    endtask

    task automatic test_stall_skid();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        tick();
        redirect_valid = 1'b0;
        id_stall       = 1'b1;
        #1;
        tick();                 // handshake pc 4
        tick();                 // response 4 -> IF/ID
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin n_fail++; $display("FAIL stall_first: got v=%b pc=%h expected v=1 pc=00000004", ifid_valid, ifid_pc); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h5) begin n_fail++; $display("FAIL stall_req5: got v=%b addr=%h expected v=1 addr=00000005", imem_req_valid, imem_req_addr); end
        tick();                 // handshake pc 5
        tick();                 // response 5 -> skid
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (ifid_pc !== 32'h4 || ifid_npc !== 32'h5 || ifid_instr !== img(32'h4) || ifid_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h npc=%h instr=%h expected v=1 pc=00000004 npc=00000005 instr=%h", c, ifid_valid, ifid_pc, ifid_npc, ifid_instr, img(32'h4));
            end
            n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_req[%0d]: got %b expected 0", c, imem_req_valid); end
            tick();
        end
        id_stall = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_req: got %b expected 0", imem_req_valid); end
        tick();                 // skid -> IF/ID
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h5 || ifid_npc !== 32'h6 || ifid_instr !== img(32'h5)) begin
            n_fail++; $display("FAIL stall_drain: got v=%b pc=%h npc=%h instr=%h expected v=1 pc=00000005 npc=00000006 instr=%h", ifid_valid, ifid_pc, ifid_npc, ifid_instr, img(32'h5));
        end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h6) begin n_fail++; $display("FAIL stall_resume: got v=%b addr=%h expected v=1 addr=00000006", imem_req_valid, imem_req_addr); end
        $display("stall: drained pc=%h, requests resume at %h", ifid_pc, imem_req_addr);
        tick();                 // handshake 6, entry 5 consumed
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed: got %b expected 0", ifid_valid); end
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h6) begin n_fail++; $display("FAIL stall_after: got v=%b pc=%h expected v=1 pc=00000006", ifid_valid, ifid_pc); end
    endtask

    task automatic test_redirect_wait();
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL rdw_req8: got v=%b addr=%h expected v=1 addr=00000008", imem_req_valid, imem_req_addr); end
        tick();                 // handshake pc 8
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();                 // WAIT -> DISCARD
        redirect_valid = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_discard[%0d]: got req_v=%b ifid_v=%b expected 0/0", c, imem_req_valid, ifid_valid); end
            tick();
        end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped: got ifid_v=%b pc=%h expected ifid_v=0", ifid_valid, ifid_pc); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin n_fail++; $display("FAIL rdw_target: got v=%b addr=%h expected v=1 addr=00000040", imem_req_valid, imem_req_addr); end
        tick();                 // handshake 0x40
        tick();
        tick();
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_latency_early: got %b expected 0", ifid_valid); end
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_instr !== img(32'h40)) begin
            n_fail++; $display("FAIL rdw_deliver: got v=%b pc=%h instr=%h expected v=1 pc=00000040 instr=%h", ifid_valid, ifid_pc, ifid_instr, img(32'h40));
        end
        $display("redirect_wait: delivered pc=%h after discard", ifid_pc);
    endtask

    task automatic test_redirect_coincident();
        lat = 1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h41) begin n_fail++; $display("FAIL rdc_req41: got v=%b addr=%h expected v=1 addr=00000041", imem_req_valid, imem_req_addr); end
        tick();                 // handshake 0x41; response arrives this cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        n_checks++; if (imem_resp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_cycle: got resp_v=%b req_v=%b expected 1/0", imem_resp_valid, imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_dropped: got v=%b pc=%h expected v=0", ifid_valid, ifid_pc); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin n_fail++; $display("FAIL rdc_target: got v=%b addr=%h expected v=1 addr=00000080", imem_req_valid, imem_req_addr); end
        tick();
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h80 || ifid_npc !== 32'h81) begin n_fail++; $display("FAIL rdc_deliver: got v=%b pc=%h npc=%h expected v=1 pc=00000080 npc=00000081", ifid_valid, ifid_pc, ifid_npc); end
        $display("redirect_coincident: delivered pc=%h", ifid_pc);
    endtask

    task automatic test_backpressure_reset();
        lat            = 3;
        imem_req_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h81) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b addr=%h expected v=1 addr=00000081", c, imem_req_valid, imem_req_addr); end
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        tick();                 // handshake 0x81, now WAIT
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_wait: got %b expected 0", imem_req_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_req: got v=%b addr=%h expected v=1 addr=00000000", imem_req_valid, imem_req_addr); end
        n_checks++; if (ifid_valid !== 1'b0 || {ifid_instr, ifid_pc, ifid_npc} !== 96'h0) begin
            n_fail++; $display("FAIL midrst_ifid: got v=%b instr=%h pc=%h npc=%h expected all zero", ifid_valid, ifid_instr, ifid_pc, ifid_npc);
        end
        tick();
        tick();
        tick();
        tick();
        n_checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== img(32'h0)) begin
            n_fail++; $display("FAIL midrst_restart: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=%h", ifid_valid, ifid_pc, ifid_instr, img(32'h0));
        end
        $display("backpressure/reset: restarted, delivered pc=%h", ifid_pc);
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_stall        = 1'b0;
        test_reset();
        test_seq_fetch();
        test_wrap();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_coincident();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
